oled_spi_rx: RTL and testbench

//  Receive-side counterpart of the Oled_Display pixel driver: snoops the PmodOLED SPI pins (cs, sdin, sclk, d_cn) and decodes them.

---
 rtl/oled_pkg.sv | 22 ++
 rtl/spi_byte_rx.sv | 84 ++++++++
 rtl/oled_spi_rx.sv | 173 +++++++++++++++++
 tb/tb_oled_spi_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared constants and types for the PmodOLED (SSD1331) SPI snooper.
// Panel geometry, window commands and the window-decode FSM states.
package oled_pkg;
    localparam int OLED_W = 96;
    localparam int OLED_H = 64;
    localparam int IDX_W  = 13;

    localparam logic [7:0] CMD_SET_COL = 8'h15;
    localparam logic [7:0] CMD_SET_ROW = 8'h75;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COL_S,
        ST_COL_E,
        ST_ROW_S,
        ST_ROW_E
    } win_state_t;

    function automatic logic [6:0] clamp_max(input logic [6:0] v, input logic [6:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction
endpackage

// File: rtl/spi_byte_rx.sv
// Synchronises the snooped SPI pins and reassembles MSB-first bytes on sclk rising edges.
// A chip-select release in the middle of a byte drops it and raises a one-cycle abort.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       i_cs,
    input  logic       i_sdin,
    input  logic       i_sclk,
    input  logic       i_d_cn,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_is_data,
    output logic       o_abort
);
    // Pin order {cs, sdin, sclk, d_cn}; cs idles high so reset never fakes a deassert edge.
    localparam logic [3:0] PIN_IDLE = 4'b1000;

    logic [SYNC_STAGES-1:0][3:0] r_sync;
    logic       r_sclk_prev;
    logic       r_cs_prev;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic       r_byte_valid;
    logic [7:0] r_byte;
    logic       r_is_data;
    logic       r_abort;

    logic [3:0] w_pins;
    logic       w_cs_s;
    logic       w_sdin_s;
    logic       w_sclk_s;
    logic       w_dcn_s;
    logic       w_rise;
    logic       w_cs_release;

    assign w_pins       = {i_cs, i_sdin, i_sclk, i_d_cn};
    assign w_cs_s       = r_sync[SYNC_STAGES-1][3];
    assign w_sdin_s     = r_sync[SYNC_STAGES-1][2];
    assign w_sclk_s     = r_sync[SYNC_STAGES-1][1];
    assign w_dcn_s      = r_sync[SYNC_STAGES-1][0];
    assign w_rise       = w_sclk_s & ~r_sclk_prev & ~w_cs_s;
    assign w_cs_release = w_cs_s & ~r_cs_prev;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_sync       <= {SYNC_STAGES{PIN_IDLE}};
            r_sclk_prev  <= 1'b0;
            r_cs_prev    <= 1'b1;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 7'd0;
            r_byte_valid <= 1'b0;
            r_byte       <= 8'd0;
            r_is_data    <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_sync       <= {r_sync[SYNC_STAGES-2:0], w_pins};
            r_sclk_prev  <= w_sclk_s;
            r_cs_prev    <= w_cs_s;
            r_byte_valid <= 1'b0;
            r_abort      <= 1'b0;
            if (w_cs_release) begin
                if (r_bit_cnt != 3'd0) begin
                    r_abort <= 1'b1;
                end
                r_bit_cnt <= 3'd0;
            end else if (w_rise) begin
                r_shift   <= {r_shift[5:0], w_sdin_s};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_valid <= 1'b1;
                    r_byte       <= {r_shift, w_sdin_s};
                    r_is_data    <= w_dcn_s;
                end
            end
        end
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte       = r_byte;
    assign o_is_data    = r_is_data;
    assign o_abort      = r_abort;
endmodule

// File: rtl/oled_spi_rx.sv
// Decodes snooped SSD1331 traffic into command bytes and RGB565 pixels with their linear index.
// Tracks the column/row address window so each pixel lands at row*WIDTH+col.
import oled_pkg::*;

module oled_spi_rx #(
    parameter int WIDTH       = OLED_W,
    parameter int HEIGHT      = OLED_H,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLOCK,
    input  logic             reset,
    input  logic             cs,
    input  logic             sdin,
    input  logic             sclk,
    input  logic             d_cn,
    output logic             cmd_valid,
    output logic [7:0]       cmd_byte,
    output logic             pix_valid,
    output logic [15:0]      pix_data,
    output logic [IDX_W-1:0] pixel_index,
    output logic             frame_done,
    output logic             err_partial
);
    localparam logic [6:0] COL_MAX = 7'(WIDTH - 1);
    localparam logic [6:0] ROW_MAX = 7'(HEIGHT - 1);

    logic             w_byte_valid;
    logic [7:0]       w_byte;
    logic             w_is_data;
    logic             w_abort;
    logic [6:0]       w_col_clamp;
    logic [6:0]       w_row_clamp;
    logic [IDX_W-1:0] w_row_ext;
    logic [IDX_W-1:0] w_row_base;
    logic [IDX_W-1:0] w_index;

    win_state_t       r_state;
    logic             r_half;
    logic [7:0]       r_hi;
    logic [6:0]       r_col;
    logic [6:0]       r_row;
    logic [6:0]       r_col_start;
    logic [6:0]       r_col_end;
    logic [6:0]       r_row_start;
    logic [6:0]       r_row_end;
    logic             r_cmd_valid;
    logic [7:0]       r_cmd_byte;
    logic             r_pix_valid;
    logic [15:0]      r_pix_data;
    logic [IDX_W-1:0] r_pixel_index;
    logic             r_frame_done;
    logic             r_err_partial;

    spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
        .clk          (CLOCK),
        .srst         (reset),
        .i_cs         (cs),
        .i_sdin       (sdin),
        .i_sclk       (sclk),
        .i_d_cn       (d_cn),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_is_data    (w_is_data),
        .o_abort      (w_abort)
    );

    assign w_col_clamp = clamp_max(w_byte[6:0], COL_MAX);
    assign w_row_clamp = clamp_max(w_byte[6:0], ROW_MAX);
    assign w_row_ext   = IDX_W'(r_row);

    // 96 = 64 + 32, so the row base is two shifted copies and needs no multiplier.
    generate
        if (WIDTH == 96) begin : g_mul96
            assign w_row_base = (w_row_ext << 6) + (w_row_ext << 5);
        end else begin : g_mul_any
            assign w_row_base = w_row_ext * IDX_W'(WIDTH);
        end
    endgenerate

    assign w_index = w_row_base + IDX_W'(r_col);

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_half        <= 1'b0;
            r_hi          <= 8'd0;
            r_col         <= 7'd0;
            r_row         <= 7'd0;
            r_col_start   <= 7'd0;
            r_col_end     <= COL_MAX;
            r_row_start   <= 7'd0;
            r_row_end     <= ROW_MAX;
            r_cmd_valid   <= 1'b0;
            r_cmd_byte    <= 8'd0;
            r_pix_valid   <= 1'b0;
            r_pix_data    <= 16'd0;
            r_pixel_index <= '0;
            r_frame_done  <= 1'b0;
            r_err_partial <= 1'b0;
        end else begin
            r_cmd_valid  <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_abort) begin
                r_err_partial <= 1'b1;
            end
            if (w_byte_valid && !w_is_data) begin
                r_cmd_valid <= 1'b1;
                r_cmd_byte  <= w_byte;
                r_half      <= 1'b0;
                if (r_half) begin
                    r_err_partial <= 1'b1;
                end
                case (r_state)
                    ST_IDLE: begin
                        if (w_byte == CMD_SET_COL) begin
                            r_state <= ST_COL_S;
                        end else if (w_byte == CMD_SET_ROW) begin
                            r_state <= ST_ROW_S;
                        end
                    end
                    ST_COL_S: begin
                        r_col_start <= w_col_clamp;
                        r_state     <= ST_COL_E;
                    end
                    ST_COL_E: begin
                        r_col_end <= (w_col_clamp < r_col_start) ? r_col_start : w_col_clamp;
                        r_col     <= r_col_start;
                        r_state   <= ST_IDLE;
                    end
                    ST_ROW_S: begin
                        r_row_start <= w_row_clamp;
                        r_state     <= ST_ROW_E;
                    end
                    ST_ROW_E: begin
                        r_row_end <= (w_row_clamp < r_row_start) ? r_row_start : w_row_clamp;
                        r_row     <= r_row_start;
                        r_state   <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (w_byte_valid && !r_half) begin
                r_hi   <= w_byte;
                r_half <= 1'b1;
            end else if (w_byte_valid) begin
                r_half        <= 1'b0;
                r_pix_valid   <= 1'b1;
                r_pix_data    <= {r_hi, w_byte};
                r_pixel_index <= w_index;
                // >= keeps a cursor left outside a freshly shrunk window from running away.
                if (r_col >= r_col_end) begin
                    r_col <= r_col_start;
                    if (r_row >= r_row_end) begin
                        r_row        <= r_row_start;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_row <= r_row + 7'd1;
                    end
                end else begin
                    r_col <= r_col + 7'd1;
                end
            end
        end
    end

    assign cmd_valid   = r_cmd_valid;
    assign cmd_byte    = r_cmd_byte;
    assign pix_valid   = r_pix_valid;
    assign pix_data    = r_pix_data;
    assign pixel_index = r_pixel_index;
    assign frame_done  = r_frame_done;
    assign err_partial = r_err_partial;
endmodule

// File: tb/tb_oled_spi_rx.sv
// Directed bench for oled_spi_rx: drives SPI bit-by-bit and checks decoded pulses against hand-computed values.
module tb_oled_spi_rx;
    logic        clk = 1'b0;
    logic        reset, cs, sdin, sclk, d_cn;
    logic        cmd_valid, pix_valid, frame_done, err_partial;
    logic [7:0]  cmd_byte;
    logic [15:0] pix_data;
    logic [12:0] pixel_index;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_rise = 0;
    int stray_fd = 0;

    typedef struct {int idx; logic [15:0] dat; logic fd; int cyc;} pix_t;
    typedef struct {logic [7:0] b; int cyc;} cmd_t;
    pix_t pix_q[$];
    cmd_t cmd_q[$];

    oled_spi_rx #(.WIDTH(96), .HEIGHT(64), .SYNC_STAGES(2)) dut (
        .CLOCK(clk), .reset(reset), .cs(cs), .sdin(sdin), .sclk(sclk), .d_cn(d_cn),
        .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .pix_valid(pix_valid), .pix_data(pix_data),
        .pixel_index(pixel_index), .frame_done(frame_done), .err_partial(err_partial)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pix_valid) pix_q.push_back('{int'(pixel_index), pix_data, frame_done, cyc});
        if (cmd_valid) cmd_q.push_back('{cmd_byte, cyc});
        if (frame_done && !pix_valid) stray_fd++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits, input logic dc);
        for (int i = 0; i < nbits; i++) begin
            sdin = b[7-i];
            d_cn = dc;
            sclk = 1'b0;
            repeat (2) @(negedge clk);
            sclk = 1'b1;
            last_rise = cyc + 1;
            repeat (2) @(negedge clk);
        end
        sclk = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        send_bits(b, 8, 1'b0);
    endtask

    task automatic send_pix(input logic [15:0] p);
        send_bits(p[15:8], 8, 1'b1);
        send_bits(p[7:0], 8, 1'b1);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic expect_pix(input string tag, input int idx, input logic [15:0] dat, input logic fd);
        pix_t p;
        p = '{-1, 16'h0, 1'b0, 0};
        if (pix_q.size() > 0) p = pix_q.pop_front();
        chk({tag, "_idx"}, p.idx, idx);
        chk({tag, "_dat"}, {16'h0, p.dat}, {16'h0, dat});
        chk({tag, "_fd"}, {31'h0, p.fd}, {31'h0, fd});
    endtask

    task automatic expect_cmd(input string tag, input logic [7:0] b);
        cmd_t c;
        c = '{8'h00, -1};
        if (cmd_q.size() > 0) c = cmd_q.pop_front();
        chk({tag, "_cmd"}, {24'h0, c.b}, {24'h0, b});
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_flags"}, {28'h0, cmd_valid, pix_valid, frame_done, err_partial}, 32'h0);
        chk({tag, "_data"}, {cmd_byte, pix_data}, 32'h0);
        chk({tag, "_index"}, {19'h0, pixel_index}, 32'h0);
    endtask

    logic [7:0] win_cmds [6] = '{8'h15, 8'h0A, 8'h0D, 8'h75, 8'h05, 8'h06};
    int         win_idx  [9] = '{490, 491, 492, 493, 586, 587, 588, 589, 490};
    logic [7:0] clp_cmds [6] = '{8'h15, 8'h7F, 8'h05, 8'h75, 8'h3E, 8'h70};
    int         clp_idx  [3] = '{6047, 6143, 6047};
    logic [7:0] cor_cmds [6] = '{8'h15, 8'h5E, 8'h5F, 8'h75, 8'h00, 8'h01};
    int         cor_idx  [4] = '{94, 95, 190, 191};

    initial begin
        reset = 1'b1; cs = 1'b1; sdin = 1'b0; sclk = 1'b0; d_cn = 1'b0;
        repeat (4) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);

        // Lone command: value, latency from 8th sclk rise, no pixel
        send_cmd(8'hAF);
        settle();
        chk("cmd_count", cmd_q.size(), 1);
        if (cmd_q.size() > 0) chk("cmd_latency", cmd_q[0].cyc - last_rise, 3);
        expect_cmd("lone", 8'hAF);
        chk("lone_no_pix", pix_q.size(), 0);

        // First pixels land at 0 and 1 with the default full window
        send_pix(16'h1234);
        settle();
        if (pix_q.size() > 0) chk("pix_latency", pix_q[0].cyc - last_rise, 3);
        expect_pix("p0", 0, 16'h1234, 1'b0);
        send_pix(16'hABCD);
        settle();
        expect_pix("p1", 1, 16'hABCD, 1'b0);

        // Window cols 10..13 rows 5..6, ninth pixel wraps to the window start
        for (int i = 0; i < 6; i++) send_cmd(win_cmds[i]);
        settle();
        chk("win_cmd_count", cmd_q.size(), 6);
        for (int i = 0; i < 6; i++) expect_cmd("win", win_cmds[i]);
        for (int i = 0; i < 9; i++) send_pix(16'h0100 + 16'(i));
        settle();
        chk("win_pix_count", pix_q.size(), 9);
        for (int i = 0; i < 9; i++) expect_pix("win", win_idx[i], 16'h0100 + 16'(i), i == 7);
        chk("win_err", {31'h0, err_partial}, 32'h0);

        // Clamping and end<start: cols 95..95 rows 62..63
        for (int i = 0; i < 6; i++) send_cmd(clp_cmds[i]);
        for (int i = 0; i < 3; i++) send_pix(16'hF000 + 16'(i));
        settle();
        cmd_q.delete();
        chk("clp_pix_count", pix_q.size(), 3);
        for (int i = 0; i < 3; i++) expect_pix("clp", clp_idx[i], 16'hF000 + 16'(i), i == 1);

        // Corner window cols 94..95 rows 0..1 crossing a row boundary
        for (int i = 0; i < 6; i++) send_cmd(cor_cmds[i]);
        for (int i = 0; i < 4; i++) send_pix(16'h7700 + 16'(i));
        settle();
        cmd_q.delete();
        for (int i = 0; i < 4; i++) expect_pix("cor", cor_idx[i], 16'h7700 + 16'(i), i == 3);

        // Odd data byte followed by a command
        send_bits(8'h55, 8, 1'b1);
        send_cmd(8'hAF);
        settle();
        chk("odd_no_pix", pix_q.size(), 0);
        expect_cmd("odd", 8'hAF);
        chk("odd_err", {31'h0, err_partial}, 32'h1);
        send_pix(16'h0F0F);
        settle();
        expect_pix("odd_next", 94, 16'h0F0F, 1'b0);

        // Reset at bit 4 of a pixel low byte
        send_bits(8'h12, 8, 1'b1);
        send_bits(8'h34, 4, 1'b1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("midrst");
        reset = 1'b0;
        settle();
        chk("midrst_no_pix", pix_q.size(), 0);
        chk("midrst_no_cmd", cmd_q.size(), 0);
        send_pix(16'hBEEF);
        send_pix(16'hC0DE);
        settle();
        expect_pix("rst0", 0, 16'hBEEF, 1'b0);
        expect_pix("rst1", 1, 16'hC0DE, 1'b0);
        chk("rst_err", {31'h0, err_partial}, 32'h0);

        // cs released after 5 bits of a data byte
        send_bits(8'hAA, 5, 1'b1);
        cs = 1'b1;
        settle();
        chk("abort_err", {31'h0, err_partial}, 32'h1);
        chk("abort_no_pix", pix_q.size(), 0);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        send_pix(16'h5678);
        settle();
        expect_pix("abort_next", 2, 16'h5678, 1'b0);
        chk("stray_frame_done", stray_fd, 0);
        chk("final_leftover", pix_q.size() + cmd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
